// File: rtl/key_evt_pkg.sv
// Shared types and defaults for the key event arbiter.
package key_evt_pkg;
    localparam int DEF_N_KEY    = 4;
    localparam int DEF_LONG_CNT = 32'd12_000_000;
    localparam int EVT_KEY_BIT  = $clog2(DEF_N_KEY);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG_DONE
    } key_state_t;

    typedef struct packed {
        logic [EVT_KEY_BIT-1:0] key;
        logic                   is_long;
    } evt_t;
endpackage

// File: rtl/key_event_arbiter_if.sv
// Key pulse inputs, event handshake and overflow flag of the key event arbiter.
interface key_event_arbiter_if #(
    parameter int N_KEY = key_evt_pkg::DEF_N_KEY
);
    localparam int KEY_BIT = $clog2(N_KEY);

    logic [N_KEY-1:0]   i_key_pos;
    logic [N_KEY-1:0]   i_key_neg;
    logic               o_evt_valid;
    logic               i_evt_ready;
    logic [KEY_BIT-1:0] o_evt_key;
    logic               o_evt_long;
    logic               o_overflow;
    logic               i_ovf_clr;

    modport master (
        output i_key_pos, i_key_neg, i_evt_ready, i_ovf_clr,
        input  o_evt_valid, o_evt_key, o_evt_long, o_overflow
    );

    modport slave (
        input  i_key_pos, i_key_neg, i_evt_ready, i_ovf_clr,
        output o_evt_valid, o_evt_key, o_evt_long, o_overflow
    );
endinterface

// File: rtl/key_hold_timer.sv
// Per-key press classifier: combinational short/long strobes in the cycle the event is decided.
// Long fires LONG_CNT cycles after the press pulse; no backpressure (strobes are one-shot).
module key_hold_timer
    import key_evt_pkg::*;
#(
    parameter int LONG_CNT = DEF_LONG_CNT,
    parameter int CNT_BIT  = $clog2(LONG_CNT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic pos,
    input  logic neg,
    output logic short_evt,
    output logic long_evt
);
    key_state_t         state, state_nxt;
    logic [CNT_BIT-1:0] cnt, cnt_nxt;
    logic               at_thr;

    assign at_thr = (cnt == CNT_BIT'(LONG_CNT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        short_evt = 1'b0;
        long_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (pos) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end
            end
            HELD: begin
                // A release on the threshold cycle still counts as the release.
                if (at_thr) begin
                    long_evt  = 1'b1;
                    state_nxt = neg ? IDLE : LONG_DONE;
                end else if (neg) begin
                    short_evt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_BIT'(1);
                end
            end
            LONG_DONE: begin
                if (neg) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: rtl/key_event_arbiter.sv
// Serializes per-key short/long press events round-robin onto one registered valid/ready stream.
// Event to valid in 2 cycles minimum; outputs hold under backpressure, repeat events drop into o_overflow.
module key_event_arbiter
    import key_evt_pkg::*;
#(
    parameter int N_KEY    = DEF_N_KEY,
    parameter int LONG_CNT = DEF_LONG_CNT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    key_event_arbiter_if.slave bus
);
    localparam int CNT_BIT = $clog2(LONG_CNT + 1);
    localparam int KEY_BIT = $clog2(N_KEY);

    logic                rst;
    logic [N_KEY-1:0]    short_evt, long_evt;
    logic [N_KEY-1:0]    pend_s, pend_l;
    logic [N_KEY-1:0]    take_s, take_l, win_oh;
    logic [KEY_BIT-1:0]  ptr, win_key, cand;
    logic                found, win_long, load, drop;
    logic                out_vld, ovf_q;
    evt_t                out_q;
    int                  slot;

    // Reset is active-high despite the port name.
    assign rst = i_rst_n;

    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        key_hold_timer #(
            .LONG_CNT (LONG_CNT),
            .CNT_BIT  (CNT_BIT)
        ) u_timer (
            .clk       (i_clk),
            .rst       (rst),
            .pos       (bus.i_key_pos[k]),
            .neg       (bus.i_key_neg[k]),
            .short_evt (short_evt[k]),
            .long_evt  (long_evt[k])
        );
    end

    always_comb begin
        found   = 1'b0;
        win_key = '0;
        cand    = '0;
        slot    = 0;
        for (int off = 0; off < N_KEY; off++) begin
            slot = int'(ptr) + off;
            if (slot >= N_KEY) begin
                slot = slot - N_KEY;
            end
            cand = KEY_BIT'(slot);
            if (!found && (pend_s[cand] || pend_l[cand])) begin
                found   = 1'b1;
                win_key = cand;
            end
        end
    end

    assign win_long = ~pend_s[win_key];
    assign load     = ~out_vld | bus.i_evt_ready;
    assign win_oh   = N_KEY'(1) << win_key;
    assign take_s   = (load && found && !win_long) ? win_oh : '0;
    assign take_l   = (load && found &&  win_long) ? win_oh : '0;
    // A set that coincides with its own grant keeps the bit and is not a drop.
    assign drop     = |((short_evt & pend_s & ~take_s) | (long_evt & pend_l & ~take_l));

    always_ff @(posedge i_clk) begin
        if (rst) begin
            pend_s  <= '0;
            pend_l  <= '0;
            ptr     <= '0;
            out_vld <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_s <= (pend_s & ~take_s) | short_evt;
            pend_l <= (pend_l & ~take_l) | long_evt;
            if (load) begin
                out_vld <= found;
                if (found) begin
                    out_q.key     <= EVT_KEY_BIT'(win_key);
                    out_q.is_long <= win_long;
                    ptr           <= (win_key == KEY_BIT'(N_KEY - 1)) ? '0 : win_key + KEY_BIT'(1);
                end
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.i_ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.o_evt_valid = out_vld;
    assign bus.o_evt_key   = KEY_BIT'(out_q.key);
    assign bus.o_evt_long  = out_q.is_long;
    assign bus.o_overflow  = ovf_q;
endmodule

// File: tb/tb_key_event_arbiter.sv
// Scenario bench for key_event_arbiter with a cycle-level behavioural event model.
module tb_key_event_arbiter;
    localparam int NK = 4;
    localparam int LC = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_event_arbiter_if #(.N_KEY(NK)) bus ();

    key_event_arbiter #(.N_KEY(NK), .LONG_CNT(LC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: key hold tracked by press time; pending as plain flags; expected registered outputs.
    bit held [NK];
    bit ldone[NK];
    int t0   [NK];
    bit pend [NK][2];
    bit ev   [NK][2];
    bit m_vld, m_long, m_ovf;
    int m_key, m_ptr;

    function automatic logic [4:0] obs();
        return {bus.o_evt_valid, bus.o_evt_key, bus.o_evt_long, bus.o_overflow};
    endfunction

    function automatic logic [4:0] mdl();
        return {m_vld, 2'(m_key), m_long, m_ovf};
    endfunction

    task automatic step(input logic [NK-1:0] pos, input logic [NK-1:0] neg,
                        input logic rdy, input logic clr, input logic r);
        int ck, ckind;
        bit drop, consumed;
        bus.i_key_pos   = pos;
        bus.i_key_neg   = neg;
        bus.i_evt_ready = rdy;
        bus.i_ovf_clr   = clr;
        rst             = r;
        if (r) begin
            for (int k = 0; k < NK; k++) begin
                held[k] = 0; ldone[k] = 0; pend[k][0] = 0; pend[k][1] = 0;
            end
            m_vld = 0; m_key = 0; m_long = 0; m_ovf = 0; m_ptr = 0;
        end else begin
            for (int k = 0; k < NK; k++) begin
                ev[k][0] = 0; ev[k][1] = 0;
                if (held[k]) begin
                    if (!ldone[k] && (cyc - t0[k] == LC)) begin
                        ev[k][1] = 1;
                        if (neg[k]) held[k] = 0; else ldone[k] = 1;
                    end else if (neg[k]) begin
                        if (!ldone[k]) ev[k][0] = 1;
                        held[k] = 0; ldone[k] = 0;
                    end
                end else if (pos[k]) begin
                    held[k] = 1; ldone[k] = 0; t0[k] = cyc;
                end
            end
            ck = -1; ckind = 0;
            if (!m_vld || rdy) begin
                for (int off = 0; off < NK; off++) begin
                    int k = (m_ptr + off) % NK;
                    if (ck < 0 && (pend[k][0] || pend[k][1])) ck = k;
                end
                m_vld = (ck >= 0);
                if (ck >= 0) begin
                    ckind  = pend[ck][0] ? 0 : 1;
                    m_key  = ck;
                    m_long = (ckind == 1);
                    m_ptr  = (ck + 1) % NK;
                end
            end
            drop = 0;
            for (int k = 0; k < NK; k++) begin
                for (int j = 0; j < 2; j++) begin
                    consumed = (ck == k) && (ckind == j);
                    if (ev[k][j]) begin
                        if (pend[k][j] && !consumed) drop = 1;
                        pend[k][j] = 1;
                    end else if (consumed) begin
                        pend[k][j] = 0;
                    end
                end
            end
            if (drop) m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        step('0, '0, 1'b1, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b1);
        n_chk++; if (bus.o_evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_evt_valid); end
        n_chk++; if (bus.o_evt_key !== 2'd0) begin n_fail++; $display("FAIL reset_key got %0d want 0", bus.o_evt_key); end
        n_chk++; if (bus.o_evt_long !== 1'b0) begin n_fail++; $display("FAIL reset_long got %b want 0", bus.o_evt_long); end
        n_chk++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus.o_overflow); end
        step('0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_short();
        for (int c = 0; c < 9; c++) begin
            step((c == 0) ? 4'b0010 : 4'b0, (c == 3) ? 4'b0010 : 4'b0, 1'b1, 1'b0, 1'b0);
            n_chk++; if (obs() !== mdl()) begin n_fail++; $display("FAIL short_model c=%0d got %b want %b", c + 1, obs(), mdl()); end
            n_chk++; if (bus.o_evt_valid !== (c + 1 == 5)) begin n_fail++; $display("FAIL short_valid c=%0d got %b", c + 1, bus.o_evt_valid); end
            if (c + 1 == 5) begin
                n_chk++; if ({bus.o_evt_key, bus.o_evt_long} !== 3'b010) begin n_fail++; $display("FAIL short_evt got key=%0d long=%b want key=1 long=0", bus.o_evt_key, bus.o_evt_long); end
            end
        end
    endtask

    task automatic test_long();
        for (int c = 0; c < 25; c++) begin
            step((c == 0) ? 4'b0100 : 4'b0, (c == 20) ? 4'b0100 : 4'b0, 1'b1, 1'b0, 1'b0);
            n_chk++; if (obs() !== mdl()) begin n_fail++; $display("FAIL long_model c=%0d got %b want %b", c + 1, obs(), mdl()); end
            n_chk++; if (bus.o_evt_valid !== (c + 1 == 10)) begin n_fail++; $display("FAIL long_valid c=%0d got %b", c + 1, bus.o_evt_valid); end
            if (c + 1 == 10) begin
                n_chk++; if ({bus.o_evt_key, bus.o_evt_long} !== 3'b101) begin n_fail++; $display("FAIL long_evt got key=%0d long=%b want key=2 long=1", bus.o_evt_key, bus.o_evt_long); end
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_key;
        step('0, '0, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 14; c++) begin
            step((c == 0) ? 4'b1011 : (c == 7) ? 4'b0101 : 4'b0,
                 (c == 2) ? 4'b1011 : (c == 9) ? 4'b0101 : 4'b0, 1'b1, 1'b0, 1'b0);
            case (c + 1)
                4: exp_key = 0;
                5: exp_key = 1;
                6: exp_key = 3;
                11: exp_key = 0;
                12: exp_key = 2;
                default: exp_key = -1;
            endcase
            n_chk++; if (obs() !== mdl()) begin n_fail++; $display("FAIL rr_model c=%0d got %b want %b", c + 1, obs(), mdl()); end
            n_chk++; if (bus.o_evt_valid !== (exp_key >= 0)) begin n_fail++; $display("FAIL rr_valid c=%0d got %b", c + 1, bus.o_evt_valid); end
            if (exp_key >= 0) begin
                n_chk++; if (bus.o_evt_key !== 2'(exp_key)) begin n_fail++; $display("FAIL rr_key c=%0d got %0d want %0d", c + 1, bus.o_evt_key, exp_key); end
            end
        end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        logic rdy;
        // Three key0 taps while stalled: one held on the outputs, one pending, one dropped.
        for (int c = 0; c < 22; c++) begin
            rdy = (c >= 15);
            if (bus.o_evt_valid && rdy) hs++;
            step((c == 0 || c == 5 || c == 10) ? 4'b0001 : 4'b0,
                 (c == 2 || c == 7 || c == 12) ? 4'b0001 : 4'b0, rdy, (c == 19), 1'b0);
            n_chk++; if (obs() !== mdl()) begin n_fail++; $display("FAIL bp_model c=%0d got %b want %b", c + 1, obs(), mdl()); end
            if (c + 1 >= 4 && c + 1 <= 15) begin
                n_chk++; if ({bus.o_evt_valid, bus.o_evt_key, bus.o_evt_long} !== 4'b1000) begin n_fail++; $display("FAIL bp_hold c=%0d got %b want 1000", c + 1, {bus.o_evt_valid, bus.o_evt_key, bus.o_evt_long}); end
            end
            if (c + 1 >= 13 && c + 1 <= 19) begin
                n_chk++; if (bus.o_overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_set c=%0d got %b want 1", c + 1, bus.o_overflow); end
            end
        end
        n_chk++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_clr got %b want 0", bus.o_overflow); end
        n_chk++; if (hs !== 2) begin n_fail++; $display("FAIL bp_handshakes got %0d want 2", hs); end
    endtask

    task automatic test_threshold_release();
        int nv = 0;
        for (int c = 0; c < 14; c++) begin
            step((c == 0) ? 4'b1000 : 4'b0, (c == 8) ? 4'b1000 : 4'b0, 1'b1, 1'b0, 1'b0);
            if (bus.o_evt_valid) nv++;
            n_chk++; if (obs() !== mdl()) begin n_fail++; $display("FAIL thr_model c=%0d got %b want %b", c + 1, obs(), mdl()); end
            if (c + 1 == 10) begin
                n_chk++; if ({bus.o_evt_valid, bus.o_evt_key, bus.o_evt_long} !== 4'b1111) begin n_fail++; $display("FAIL thr_evt got %b want 1111", {bus.o_evt_valid, bus.o_evt_key, bus.o_evt_long}); end
            end
        end
        n_chk++; if (nv !== 1) begin n_fail++; $display("FAIL thr_count got %0d want 1", nv); end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        for (int c = 0; c < 18; c++) begin
            step((c == 0) ? 4'b0011 : (c == 12) ? 4'b0001 : 4'b0,
                 (c == 2) ? 4'b0010 : (c == 7 || c == 14) ? 4'b0001 : 4'b0,
                 (c > 5), 1'b0, (c == 5));
            n_chk++; if (obs() !== mdl()) begin n_fail++; $display("FAIL rst_model c=%0d got %b want %b", c + 1, obs(), mdl()); end
            if (c + 1 == 5) begin
                n_chk++; if ({bus.o_evt_valid, bus.o_evt_key} !== 3'b101) begin n_fail++; $display("FAIL rst_pre got %b want 101", {bus.o_evt_valid, bus.o_evt_key}); end
            end
            if (c + 1 == 6) begin
                n_chk++; if (obs() !== 5'b0) begin n_fail++; $display("FAIL rst_clear got %b want 00000", obs()); end
            end
            if (c + 1 > 6 && bus.o_evt_valid) nv++;
            if (c + 1 == 16) begin
                n_chk++; if ({bus.o_evt_valid, bus.o_evt_key, bus.o_evt_long} !== 4'b1000) begin n_fail++; $display("FAIL rst_new got %b want 1000", {bus.o_evt_valid, bus.o_evt_key, bus.o_evt_long}); end
            end
        end
        n_chk++; if (nv !== 1) begin n_fail++; $display("FAIL rst_count got %0d want 1", nv); end
    endtask

    task automatic test_random();
        logic [NK-1:0] p, n;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NK; k++) begin
                p[k] = ($urandom_range(0, 5) == 0);
                n[k] = ($urandom_range(0, 5) == 0);
            end
            step(p, n, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
            n_chk++; if (obs() !== mdl()) begin n_fail++; $display("FAIL rand_model c=%0d got %b want %b", cyc, obs(), mdl()); end
        end
    endtask

    initial begin
        bus.i_key_pos   = '0;
        bus.i_key_neg   = '0;
        bus.i_evt_ready = 1'b1;
        bus.i_ovf_clr   = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_round_robin();
        test_backpressure();
        test_threshold_release();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
